// File: rtl/echo_distance.sv
// echo_distance: ultrasonic echo-width to range converter.
// Waits for trig_done, times the echo pulse in microseconds and converts it
// to centimetres. It reports the result with dist_valid, or pulses timeout
// when the measurement window expires.
// Optional macro ECHO_AVG4_EN: distance_cm reports the running mean of the
// last four valid samples instead of the latest sample.
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | waiting for trig_done
// WAIT_RISE | waiting for a synchronized echo low-to-high transition
// MEASURE   | echo high; counting microseconds and centimetres
// DONE      | one cycle; result is loaded and strobed on exit
module echo_distance #(
    parameter int CLK_PER_US = 100,
    parameter int US_PER_CM  = 58,
    parameter int TIMEOUT_US = 38000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       echo,
    input  logic       trig_done,
    output logic [9:0] distance_cm,
    output logic       dist_valid,
    output logic       timeout,
    output logic       busy
);

    localparam int PW   = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
    localparam int SW   = (US_PER_CM > 1) ? $clog2(US_PER_CM) : 1;
    localparam int UW   = $clog2(TIMEOUT_US + 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_PER_US - 1);
    localparam logic [SW-1:0] SUB_LAST   = SW'(US_PER_CM - 1);
    localparam logic [UW-1:0] US_LAST    = UW'(TIMEOUT_US - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_RISE = 2'd1,
        MEASURE   = 2'd2,
        DONE      = 2'd3
    } state_t;

    state_t        state, state_next;
    logic          echo_s1, echo_s2, echo_d;
    logic          echo_rise, echo_fall;
    logic [PW-1:0] presc;
    logic [UW-1:0] us_cnt;
    logic [SW-1:0] sub_cnt;
    logic [9:0]    cm_cnt;
    logic          tick;
    logic          clear_cnt;
    logic          load_dist;
    logic          abandon;

    assign echo_rise = echo_s2 & ~echo_d;
    assign echo_fall = ~echo_s2 & echo_d;
    assign tick      = (presc == PRESC_LAST);
    assign busy      = (state != IDLE);

    // Two-flop synchronizer plus a delayed copy for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            echo_s1 <= 1'b0;
            echo_s2 <= 1'b0;
            echo_d  <= 1'b0;
        end else begin
            echo_s1 <= echo;
            echo_s2 <= echo_s1;
            echo_d  <= echo_s2;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state decode; a falling edge beats the timeout in the same cycle.
    always_comb begin
        state_next = state;
        clear_cnt  = 1'b0;
        load_dist  = 1'b0;
        abandon    = 1'b0;
        case (state)
            IDLE: begin
                if (trig_done) begin
                    state_next = WAIT_RISE;
                    clear_cnt  = 1'b1;
                end
            end
            WAIT_RISE: begin
                if (echo_rise) begin
                    state_next = MEASURE;
                    clear_cnt  = 1'b1;
                end else if (tick && us_cnt == US_LAST) begin
                    state_next = IDLE;
                    abandon    = 1'b1;
                end
            end
            MEASURE: begin
                if (echo_fall) begin
                    state_next = DONE;
                end else if (tick && us_cnt == US_LAST) begin
                    state_next = IDLE;
                    abandon    = 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
                load_dist  = 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

    // Microsecond prescaler and range counters; cm_cnt saturates at 1023.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc   <= '0;
            us_cnt  <= '0;
            sub_cnt <= '0;
            cm_cnt  <= '0;
        end else if (clear_cnt) begin
            presc   <= '0;
            us_cnt  <= '0;
            sub_cnt <= '0;
            cm_cnt  <= '0;
        end else if (state == WAIT_RISE || state == MEASURE) begin
            presc <= tick ? '0 : presc + 1'b1;
            if (tick) begin
                us_cnt <= us_cnt + 1'b1;
                if (state == MEASURE) begin
                    if (sub_cnt == SUB_LAST) begin
                        sub_cnt <= '0;
                        if (cm_cnt != 10'd1023) cm_cnt <= cm_cnt + 1'b1;
                    end else begin
                        sub_cnt <= sub_cnt + 1'b1;
                    end
                end
            end
        end
    end

    // Registered result strobes, asserted on the edge that leaves DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dist_valid <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            dist_valid <= load_dist;
            timeout    <= abandon;
        end
    end

`ifdef ECHO_AVG4_EN
    // The incoming sample is the fourth history entry; only the three
    // older ones need storage.
    logic [9:0]  hist0, hist1, hist2;
    logic        hist_full;
    logic [11:0] avg_sum;

    assign avg_sum = {2'b00, cm_cnt} + {2'b00, hist0} + {2'b00, hist1} + {2'b00, hist2};

    // History update and averaged output; the first sample fills every slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist0       <= '0;
            hist1       <= '0;
            hist2       <= '0;
            hist_full   <= 1'b0;
            distance_cm <= '0;
        end else if (load_dist) begin
            hist_full <= 1'b1;
            hist0     <= cm_cnt;
            if (hist_full) begin
                hist1       <= hist0;
                hist2       <= hist1;
                distance_cm <= avg_sum[11:2];
            end else begin
                hist1       <= cm_cnt;
                hist2       <= cm_cnt;
                distance_cm <= cm_cnt;
            end
        end
    end
`else
    // Output register loads the latest range directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         distance_cm <= '0;
        else if (load_dist) distance_cm <= cm_cnt;
    end
`endif

endmodule
